// File: rtl/v810_prefetch.sv
// V810 instruction prefetch unit: fetches 32-bit words from the instruction
// cache and presents them as a halfword queue to the decoder, handling
// redirects (including one that lands while a fetch is in flight).
module v810_prefetch #(
    parameter int QDEPTH = 8
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        ICMAINT,
    input  logic        JMP,
    input  logic [31:0] JMPA,
    output logic [31:0] FIA,
    output logic        FIREQ,
    input  logic [31:0] FID,
    input  logic        FIACK,
    output logic [15:0] IQ_HW0,
    output logic [15:0] IQ_HW1,
    output logic [31:0] IQ_PC,
    output logic [3:0]  IQ_CNT,
    input  logic [1:0]  IQ_POP
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISCARD
    } state_e;

    // Circular-buffer pointer advance; QDEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [3:0] n);
        logic [PW+4:0] s;
        s = {5'd0, p} + {{(PW + 1){1'b0}}, n};
        if (s >= (PW + 5)'(QDEPTH)) begin
            s = s - (PW + 5)'(QDEPTH);
        end
        return PW'(s);
    endfunction

    state_e        state_q, state_d;
    logic [31:0]   fia_q, fia_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:1]   tgt_q, tgt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          mis_q, mis_d;
    logic [15:0]   mem_q [QDEPTH];

    logic [3:0]    pop_req, popped, cnt_pop, push_n, cnt_after;
    logic          complete, issue_ok, load_tgt;
    logic [31:1]   tgt_addr;
    logic [PW-1:0] tail0, tail1;
    logic          jmpa0_unused;

    // Halfword alignment of a redirect lives in IQ_PC; bit 0 carries nothing.
    assign jmpa0_unused = JMPA[0];

    // State register: every update is qualified by CE, reset included.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end
    end

    // Next state: issue when there is room for a whole word, redirect handling.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (JMP) begin
                    state_d = ICMAINT ? ST_IDLE : ST_FETCH;
                end else if (issue_ok) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (JMP) begin
                    if (complete) begin
                        state_d = ICMAINT ? ST_IDLE : ST_FETCH;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else if (complete) begin
                    state_d = issue_ok ? ST_FETCH : ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (complete) begin
                    state_d = ICMAINT ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        FIREQ  = (state_q != ST_IDLE);
        FIA    = fia_q;
        IQ_PC  = pc_q;
        IQ_CNT = cnt_q;
        IQ_HW0 = mem_q[rd_q];
        IQ_HW1 = mem_q[ptr_add(rd_q, 4'd1)];
    end

    // Datapath next values: pop accounting, push sizing, fetch address and redirect target.
    always_comb begin
        pop_req   = (IQ_POP == 2'd3) ? 4'd2 : {2'b00, IQ_POP};
        popped    = (pop_req > cnt_q) ? cnt_q : pop_req;
        cnt_pop   = cnt_q - popped;
        complete  = FIREQ & FIACK;

        push_n = 4'd0;
        if (state_q == ST_FETCH && complete && !JMP) begin
            // The first word after a redirect to an odd halfword only carries its upper half.
            push_n = mis_q ? 4'd1 : 4'd2;
        end
        cnt_after = cnt_pop + push_n;
        issue_ok  = !ICMAINT && !JMP && ((4'(QDEPTH) - cnt_after) >= 4'd2);

        load_tgt = 1'b0;
        tgt_addr = JMPA[31:1];
        case (state_q)
            ST_IDLE:  load_tgt = JMP;
            ST_FETCH: load_tgt = JMP & complete;
            ST_DISCARD: begin
                if (complete) begin
                    load_tgt = 1'b1;
                    tgt_addr = JMP ? JMPA[31:1] : tgt_q;
                end
            end
            default: load_tgt = 1'b0;
        endcase

        // The fetch address only moves when no request is pending on it.
        fia_d = fia_q;
        mis_d = mis_q;
        if (load_tgt) begin
            fia_d = {tgt_addr[31:2], 2'b00};
            mis_d = tgt_addr[1];
        end else if (push_n != 4'd0) begin
            fia_d = fia_q + 32'd4;
            mis_d = 1'b0;
        end

        cnt_d = JMP ? 4'd0 : cnt_after;
        pc_d  = JMP ? {JMPA[31:1], 1'b0} : pc_q + {27'd0, popped, 1'b0};
        rd_d  = JMP ? rd_q : ptr_add(rd_q, popped);
        tgt_d = JMP ? JMPA[31:1] : tgt_q;

        tail0 = ptr_add(rd_q, cnt_q);
        tail1 = ptr_add(tail0, 4'd1);
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (CE) begin
            // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
            if (RES) begin
                fia_q <= 32'hFFFF_FFF0;
                pc_q  <= 32'hFFFF_FFF0;
                tgt_q <= '0;
                cnt_q <= '0;
                rd_q  <= '0;
                mis_q <= 1'b0;
            end else begin
                fia_q <= fia_d;
                pc_q  <= pc_d;
                tgt_q <= tgt_d;
                cnt_q <= cnt_d;
                rd_q  <= rd_d;
                mis_q <= mis_d;
            end
        end
    end

    // Queue storage: write the fetched halfwords at the tail, lower address first.
    always_ff @(posedge CLK) begin
        // NOTE: storage is deliberately not reset; entries beyond IQ_CNT are don't-care.
        if (CE && !RES && push_n != 4'd0) begin
            if (mis_q) begin
                mem_q[tail0] <= FID[31:16];
            end else begin
                mem_q[tail0] <= FID[15:0];
                mem_q[tail1] <= FID[31:16];
            end
        end
    end

endmodule
